// File: rtl/better_neighbor_scan_pkg.sv
// better_neighbor_scan_pkg: shared FSM encoding, datapath width and LFSR tap mask
package better_neighbor_scan_pkg;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
endpackage

// File: rtl/better_neighbor_scan_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR; a nonzero seed keeps it out of the all-zero lockup state
module lfsr16
  import better_neighbor_scan_pkg::*;
#(
  parameter logic [DATA_W-1:0] SEED = 16'hACE1
) (
  input  logic              clock,
  input  logic              nrst,
  output logic [DATA_W-1:0] value
);
  always_ff @(posedge clock or negedge nrst)
    if (!nrst) value <= SEED;
    else value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : '0);
endmodule

// File: rtl/better_neighbor_scan.sv
// better_neighbor_scan: streams neighbor costs, logs indices cheaper than the current solution.
// Define BNS_TIE_ACCEPT_EN to also accept neighbors whose cost equals the current cost.
module better_neighbor_scan
  import better_neighbor_scan_pkg::*;
#(
  parameter logic [DATA_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clock,
  input  logic              nrst,
  input  logic              start_scan,
  input  logic [DATA_W-1:0] current_cost,
  input  logic [DATA_W-1:0] num_neighbors,
  output logic              nb_rd_en,
  output logic [DATA_W-1:0] nb_addr,
  input  logic [DATA_W-1:0] nb_cost,
  output logic              cand_wr_en,
  output logic [DATA_W-1:0] cand_wr_addr,
  output logic [DATA_W-1:0] cand_wr_data,
  output logic [DATA_W-1:0] betterNeighborCount,
  output logic [DATA_W-1:0] which,
  output logic              done_scan
);
  state_t state;
  logic [DATA_W-1:0] cost_q, n_q, count, idx_q, lfsr;
  logic rd_q, hit, accept;
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clock(clock), .nrst(nrst), .value(lfsr));
`ifdef BNS_TIE_ACCEPT_EN
  assign hit = rd_q && (nb_cost <= cost_q);
`else
  assign hit = rd_q && (nb_cost < cost_q);
`endif
  assign accept = start_scan && (state == IDLE || state == DONE);
  // rd_q/idx_q track the read whose data is on nb_cost this cycle
  always_ff @(posedge clock or negedge nrst)
    if (!nrst) begin
      state <= IDLE;
      nb_rd_en <= 1'b0;
      nb_addr <= '0;
      cand_wr_en <= 1'b0;
      cand_wr_addr <= '0;
      cand_wr_data <= '0;
      betterNeighborCount <= '0;
      which <= '0;
      done_scan <= 1'b0;
      count <= '0;
      cost_q <= '0;
      n_q <= '0;
      idx_q <= '0;
      rd_q <= 1'b0;
    end else begin
      rd_q <= nb_rd_en;
      idx_q <= nb_addr;
      cand_wr_en <= hit;
      if (hit) begin
        cand_wr_addr <= count;
        cand_wr_data <= idx_q;
        count <= count + 16'd1;
      end
      if (accept) begin
        cost_q <= current_cost;
        n_q <= num_neighbors;
        count <= '0;
        done_scan <= 1'b0;
        nb_addr <= '0;
        nb_rd_en <= num_neighbors != '0;
        state <= num_neighbors != '0 ? SCAN : DONE;
      end else begin
        case (state)
          SCAN:
            if (nb_addr == n_q - 16'd1) begin
              nb_rd_en <= 1'b0;
              state <= DRAIN;
            end else nb_addr <= nb_addr + 16'd1;
          DRAIN: state <= DONE;
          DONE:
            if (!done_scan) begin
              done_scan <= 1'b1;
              betterNeighborCount <= count;
              which <= lfsr;
            end
          default: ;
        endcase
      end
    end
endmodule

// File: doc/better_neighbor_scan.md
BETTER_NEIGHBOR_SCAN -- requirements
Module: better_neighbor_scan

Interface
REQ-001 Parameter: LFSR_SEED, 16'hACE1, nonzero reset value of the random-number LFSR.
REQ-002 Port: clock  in  1  single clock; all state updates on rising edge.
REQ-003 Port: nrst  in  1  reset, asynchronous, active-low.
REQ-004 Port: start_scan  in  1  one-cycle request to begin a scan; sampled only in IDLE or DONE.
REQ-005 Port: current_cost  in  16  cost of current solution; latched on accepted start.
REQ-006 Port: num_neighbors  in  16  number of neighbors to scan; latched on accepted start.
REQ-007 Port: nb_rd_en  out  1  neighbor-cost memory read strobe.
REQ-008 Port: nb_addr  out  16  neighbor index being read.
REQ-009 Port: nb_cost  in  16  neighbor cost; valid exactly one cycle after nb_rd_en.
REQ-010 Port: cand_wr_en  out  1  candidate-buffer write strobe.
REQ-011 Port: cand_wr_addr  out  16  candidate slot, equal to the pre-increment count.
REQ-012 Port: cand_wr_data  out  16  index of the better neighbor.
REQ-013 Port: betterNeighborCount  out  16  number of better neighbors found; stable while done_scan=1.
REQ-014 Port: which  out  16  random value for the downstream address stage; stable while done_scan=1.
REQ-015 Port: done_scan  out  1  scan complete; outputs valid.

Function
REQ-016 FSM states IDLE, SCAN, DRAIN, DONE; IDLE->SCAN on start_scan with num_neighbors>0; IDLE->DONE on start_scan with num_neighbors=0.
REQ-017 SCAN: nb_rd_en=1, nb_addr increments 0..num_neighbors-1, one read per cycle; after last address go to DRAIN.
REQ-018 Compare pipeline: in the cycle after each read, if nb_cost < latched current_cost, assert cand_wr_en for one cycle with cand_wr_data=read index and cand_wr_addr=count, then increment count.
REQ-019 DRAIN: one cycle, completes the compare of the last read, no read issued; then DONE.
REQ-020 Latency: done_scan rises num_neighbors+2 cycles after the accepted start edge (1 cycle when num_neighbors=0).
REQ-021 On entry to DONE, betterNeighborCount <= count and which <= current LFSR value; both held until next accepted start.
REQ-022 DONE: done_scan=1 and held; start_scan in DONE clears done_scan, clears count, relatches inputs, and goes to SCAN (or DONE again if num_neighbors=0) next cycle.
REQ-023 start_scan during SCAN or DRAIN is ignored; input changes to current_cost/num_neighbors mid-scan have no effect.
REQ-024 LFSR: 16-bit Galois, taps mask 16'hB400, shifts every cycle in all states; never reaches zero.
REQ-025 Count arithmetic 16-bit unsigned; count never exceeds num_neighbors, so no wrap occurs.

Reset
REQ-026 nrst low asynchronously forces: state IDLE, nb_rd_en=0, nb_addr=0, cand_wr_en=0, cand_wr_addr=0, cand_wr_data=0, betterNeighborCount=0, which=0, done_scan=0, count=0, LFSR=LFSR_SEED.
REQ-027 Reset mid-scan aborts the scan; no further cand_wr_en pulses occur after nrst falls.

Configuration
REQ-028 Macro BNS_TIE_ACCEPT_EN: when defined, compare is nb_cost <= current_cost (ties count as better); when undefined, strict nb_cost < current_cost.

Structure
REQ-029 Shared package holds the FSM state encoding, DATA_W=16, and the LFSR tap mask constant.
REQ-030 One sub-module, lfsr16, holds the free-running LFSR with seed parameter; all else in the top.

Verification
REQ-031 num_neighbors=4, current_cost=100, costs {120,50,100,90} -> writes (addr0,data1),(addr1,data3); betterNeighborCount=2; done_scan at start+6.
REQ-032 Same stimulus with BNS_TIE_ACCEPT_EN -> writes indices 1,2,3 at slots 0,1,2; betterNeighborCount=3.
REQ-033 num_neighbors=0 -> no nb_rd_en, done_scan next cycle, betterNeighborCount=0.
REQ-034 num_neighbors=3, all costs 200 vs current 10 -> no cand_wr_en; betterNeighborCount=0; which nonzero.
REQ-035 nrst pulsed low at cycle 3 of an 8-neighbor scan -> all outputs reset immediately, no writes afterwards, LFSR restarts at 16'hACE1.
REQ-036 start_scan repeated mid-scan and again in DONE -> first ignored; second restarts with count cleared and done_scan low next cycle.
